div_seq_unit: RTL
=================

Name: div_seq_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the execute stage, alongside the ALU.
- Consumes the ALU's operand pair `a`/`b` on a div instruction and produces `quotient`/`remainder` for the HI/LO write.
- `busy` drives the pipeline stall logic, so the combinational divide path leaves the critical path.

Parameters:
- WIDTH, 32, operand and result width in bits
- CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a divide; sampled on rising edge of clk
- is_signed  input  1  signed-divide select; only honoured with DIV_SIGNED_EN
- flush  input  1  pipeline flush; cancels an in-flight divide
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- busy  output  1  divide in progress; stall request to hazard unit
- done  output  1  one-cycle pulse; results valid, HI/LO write enable
- quotient  output  WIDTH  quotient, routed to LO
- remainder  output  WIDTH  remainder, routed to HI
- div_by_zero  output  1  set with done when b was 0

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, div_by_zero=0; quotient=0, remainder=0; counter=0.
- States:
  - IDLE: waiting for a request.
  - RUN: 32 iterations in progress.
  - DONE: one cycle, results valid.
- IDLE or DONE with start=1 at edge of cycle n:
  - latch a, b; clear the partial remainder; counter=0.
  - b!=0: go to RUN.
  - b==0: go to DONE with quotient=all ones, remainder=a, div_by_zero=1.
- RUN: each edge performs one shift-subtract step.
  - Shift {rem,quo} left 1.
  - Trial subtract: rem - b, computed WIDTH+1 bits wide.
  - Non-negative result: rem=difference, quo LSB=1. Otherwise quo LSB=0.
  - counter increments; after the 32nd step (counter==WIDTH-1) go to DONE.
- Timing for b!=0:
  - busy=1 in cycles n+1..n+32.
  - done=1 in cycle n+33 only; busy=0 in n+33.
  - Total latency 33 cycles from the start edge.
- Timing for b==0: done=1 in cycle n+1; busy never asserts.
- div_by_zero: meaningful only while done=1; cleared on the next accepted start.
- DONE returns to IDLE next edge unless start=1; start is accepted directly in DONE (back-to-back divides).
- start while in RUN: ignored; the operation in flight is unaffected.
- quotient/remainder: update only on entry to DONE; hold until the next DONE entry, reset, or never (flush).
- flush=1: next edge forces IDLE; busy=0, no done.
  - quotient/remainder keep their previous values.
  - flush has priority over start in the same cycle.
- rst has priority over flush and start. Reset mid-RUN aborts with all outputs at reset values next cycle.
- Internal arithmetic is unsigned. No overflow is possible in the unsigned mode.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined, with is_signed=1 at start:
  - latch |a| and |b| (two's complement);
  - quotient is negated if a[31]^b[31];
  - remainder takes the sign of a;
  - the sign fix-up is applied on DONE entry, so latency is unchanged (33 cycles).
- Defined, signed corner cases:
  - 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0 (wraps).
  - b==0 gives the same result as the unsigned rule.
- Not defined: is_signed is ignored, the port stays present, and all divides are unsigned.

Test Plan:
- start, a=100, b=7 at cycle n -> busy in n+1..n+32; done in n+33 with quotient=14, remainder=2, div_by_zero=0.
- a=0xFFFFFFFF, b=1; then start again in the done cycle with a=10, b=3 -> first result q=0xFFFFFFFF, r=0; second done 33 cycles later with q=3, r=1.
- a=5, b=0 -> done in n+1; q=0xFFFFFFFF, r=5, div_by_zero=1; busy stays 0.
- a=100, b=7; at n+10 pulse start with a=9, b=3; at n+20 assert flush -> the n+10 start is ignored; busy drops at n+21; no done; q/r keep the prior values.
- rst asserted mid-RUN -> next cycle all outputs 0 and state IDLE; a new start then completes normally.
- DIV_SIGNED_EN, is_signed=1, a=0xFFFFFFF9 (-7), b=2 -> done in n+33 with q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).

Source files
------------

// File: rtl/div_seq_unit.sv
// Multi-cycle radix-2 restoring divider (32 shift-subtract steps, result on DONE).
// Optional signed mode is compiled in with `define DIV_SIGNED_EN.
module div_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] rem_r, quo_r, div_r;
    logic [CNT_W-1:0] cnt;
    logic             neg_q_r, neg_r_r;

    logic             accept;
    logic             last_step;
    logic             signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             take;
    logic [WIDTH-1:0] rem_nx, quo_nx;

`ifdef DIV_SIGNED_EN
    assign signed_op = is_signed;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign signed_op        = 1'b0;
`endif

    assign a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign accept    = start && !flush && (state_q == IDLE || state_q == DONE);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // Trial subtract one bit wider than the shifted remainder so the sign bit is the borrow.
    always_comb begin
        rem_sh = {rem_r, quo_r[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, div_r};
        take   = ~diff[WIDTH+1];
        rem_nx = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_r[WIDTH-2:0], take};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (b == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_d = (b == '0) ? DONE : RUN;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r       <= '0;
            quo_r       <= '0;
            div_r       <= '0;
            cnt         <= '0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem_r       <= '0;
            quo_r       <= a_mag;
            div_r       <= b_mag;
            cnt         <= '0;
            neg_q_r     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r     <= signed_op & a[WIDTH-1];
            div_by_zero <= (b == '0);
            if (b == '0) begin
                quotient  <= '1;
                remainder <= a;
            end
        end else if (state_q == RUN && !flush) begin
            rem_r <= rem_nx;
            quo_r <= quo_nx;
            cnt   <= cnt + 1'b1;
            // Sign fix-up rides on the final step so latency is identical in both modes.
            if (last_step) begin
                quotient  <= neg_q_r ? (~quo_nx + 1'b1) : quo_nx;
                remainder <= neg_r_r ? (~rem_nx + 1'b1) : rem_nx;
            end
        end
    end

endmodule
